// File: rtl/multi_debouncer.sv
// NCH-channel button debouncer: 2-flop synchroniser, per-channel confirm FSM, edge pulses.
// Define LONG_PRESS_EN to build the per-channel long-press detector; otherwise long_press is 0.
module multi_debouncer #(
  parameter int NCH       = 4,
  parameter int N         = 50,
  parameter bit HOLD_MODE = 1'b1,
  parameter int LONG_N    = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] btn,
  input  logic [NCH-1:0] done,
  output logic [NCH-1:0] btn_db,
  output logic [NCH-1:0] press_pulse,
  output logic [NCH-1:0] release_pulse,
  output logic [NCH-1:0] long_press
);

  localparam int            CW      = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (NCH < 1 || N < 1 || LONG_N < 1) begin : g_bad_params
    $error("multi_debouncer: NCH, N and LONG_N must all be >= 1");
  end

  // state           | meaning
  // IDLE            | released, waiting for s=1
  // CONFIRM_PRESS   | counting consecutive s=1 samples
  // HELD            | press confirmed (hold mode: waiting for done)
  // CONFIRM_RELEASE | counting consecutive s=0 samples
  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_e;

  logic [NCH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int            LW      = $clog2(LONG_N + 1);
  localparam logic [LW-1:0] LNG_MAX = LW'(LONG_N);
  localparam logic [LW-1:0] LNG_HIT = LW'(LONG_N - 1);

  if (LONG_N <= N) begin : g_bad_long_n
    $error("multi_debouncer: LONG_N must be greater than N");
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          db_q, pp_q, rp_q;
    logic          s;

    assign s                = sync2_q[i];
    assign btn_db[i]        = db_q;
    assign press_pulse[i]   = pp_q;
    assign release_pulse[i] = rp_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        pp_q    <= 1'b0;
        rp_q    <= 1'b0;
      end else begin
        pp_q <= 1'b0;
        rp_q <= 1'b0;
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (s) begin
              state_q <= CONFIRM_PRESS;
              cnt_q   <= CNT_ONE;
            end
          end
          CONFIRM_PRESS: begin
            if (!s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q <= HELD;
              cnt_q   <= '0;
              db_q    <= 1'b1;
              pp_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HELD: begin
            cnt_q <= '0;
            if (HOLD_MODE) begin
              if (done[i]) begin
                state_q <= CONFIRM_RELEASE;
                db_q    <= 1'b0;
                rp_q    <= 1'b1;
              end
            end else if (!s) begin
              state_q <= CONFIRM_RELEASE;
              cnt_q   <= CNT_ONE;
            end
          end
          CONFIRM_RELEASE: begin
            if (!s) begin
              if (cnt_q == CNT_MAX) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                if (!HOLD_MODE) begin
                  db_q <= 1'b0;
                  rp_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              // Hold mode stays here so a still-held button cannot re-trigger after done.
              cnt_q <= '0;
              if (!HOLD_MODE) state_q <= HELD;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

`ifdef LONG_PRESS_EN
    logic [LW-1:0] hcnt_q;
    logic          armed_q, lp_q;

    assign long_press[i] = lp_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt_q  <= '0;
        armed_q <= 1'b0;
        lp_q    <= 1'b0;
      end else begin
        lp_q <= 1'b0;
        if (state_q == CONFIRM_PRESS && s && cnt_q == CNT_MAX) begin
          hcnt_q  <= '0;
          armed_q <= 1'b1;
        end else if (state_q == HELD || state_q == CONFIRM_RELEASE) begin
          if (armed_q) begin
            if (!s) begin
              hcnt_q  <= '0;
              armed_q <= 1'b0;
            end else if (hcnt_q == LNG_HIT) begin
              hcnt_q  <= LNG_MAX;
              armed_q <= 1'b0;
              lp_q    <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
        end else begin
          hcnt_q  <= '0;
          armed_q <= 1'b0;
        end
      end
    end
`endif
  end

`ifndef LONG_PRESS_EN
  assign long_press = '0;
`endif

endmodule
